// File: rtl/buffer_pipe_stage.sv
// buffer_pipe_stage: valid/ready pipeline register with optional two-entry skid, flush and stall counter
module buffer_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  logic              r_v0, r_v1, r_ready;
  logic [DATA_W-1:0] r_d0, r_d1;
  logic [CTRL_W-1:0] r_c0, r_c1;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc, w_emit, w_v0_nxt, w_v1_nxt;
  // Handshake decode and next occupancy; the skid slot only fills when the head is held
  always_comb begin
    o_ready  = !rst && ((SKID != 0) ? r_ready : (!r_v0 || i_ready));
    w_acc    = i_valid && o_ready;
    w_emit   = r_v0 && i_ready;
    w_v0_nxt = r_v1 || w_acc || (r_v0 && !w_emit);
    w_v1_nxt = (SKID != 0) && (r_v1 ? !w_emit : (w_acc && r_v0 && !w_emit));
  end
  // Entry storage: head refills from the skid first so order is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_ready <= 1'b1;
      r_d0    <= '0;
      r_d1    <= '0;
      r_c0    <= CTRL_BUBBLE;
      r_c1    <= CTRL_BUBBLE;
    end else if (i_flush) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (w_emit && r_v1) begin
        r_d0 <= r_d1;
        r_c0 <= r_c1;
      end else if (w_acc && (!r_v0 || w_emit)) begin
        r_d0 <= i_data;
        r_c0 <= i_ctrl;
      end
      if (w_acc && r_v0 && !w_emit) begin
        r_d1 <= i_data;
        r_c1 <= i_ctrl;
      end
      r_v0    <= w_v0_nxt;
      r_v1    <= w_v1_nxt;
      r_ready <= !w_v1_nxt;
    end
  end
  // Saturating count of cycles the head is blocked downstream
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (r_v0 && !i_ready && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign o_valid     = r_v0;
  assign o_data      = r_d0;
  assign o_ctrl      = r_v0 ? r_c0 : CTRL_BUBBLE;
  assign o_occupancy = {r_v1, r_v0 && !r_v1};
  assign o_stall_cnt = r_cnt;
endmodule

// File: tb/tb_buffer_pipe_stage.sv
// tb_buffer_pipe_stage: directed checks of skid and single-entry pipe stages
module tb_buffer_pipe_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic        a_rst, a_iv, a_or, a_fl, a_ov, a_ir;
  logic [31:0] a_id, a_od;
  logic [7:0]  a_ic, a_oc;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;
  logic        b_rst, b_iv, b_or, b_fl, b_ov, b_ir;
  logic [31:0] b_id, b_od;
  logic [7:0]  b_ic, b_oc;
  logic [1:0]  b_occ;
  logic [2:0]  b_cnt;
  buffer_pipe_stage #(.SKID(1)) u_a (
    .clk(clk), .rst(a_rst), .i_valid(a_iv), .o_ready(a_or), .i_data(a_id), .i_ctrl(a_ic),
    .i_flush(a_fl), .o_valid(a_ov), .i_ready(a_ir), .o_data(a_od), .o_ctrl(a_oc),
    .o_occupancy(a_occ), .o_stall_cnt(a_cnt));
  buffer_pipe_stage #(.SKID(0), .CNT_W(3), .CTRL_BUBBLE(8'h0F)) u_b (
    .clk(clk), .rst(b_rst), .i_valid(b_iv), .o_ready(b_or), .i_data(b_id), .i_ctrl(b_ic),
    .i_flush(b_fl), .o_valid(b_ov), .i_ready(b_ir), .o_data(b_od), .o_ctrl(b_oc),
    .o_occupancy(b_occ), .o_stall_cnt(b_cnt));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [31:0] d);
    a_iv = 1; a_id = d; a_ic = 8'h81;
  endtask
  initial begin
    a_rst = 1; a_iv = 0; a_id = 0; a_ic = 0; a_fl = 0; a_ir = 0;
    b_rst = 1; b_iv = 0; b_id = 0; b_ic = 0; b_fl = 0; b_ir = 0;
    repeat (3) step();
    chk("rst_ready", a_or, 0);
    chk("rst_valid", a_ov, 0);
    chk("rst_ctrl", a_oc, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_occ", a_occ, 0);
    a_rst = 0; #1;
    chk("ready_after_rst", a_or, 1);
    a_ir = 1;
    for (int k = 1; k <= 8; k++) begin
      push_a(k);
      step();
      chk("stream_valid", a_ov, 1);
      chk("stream_data", a_od, k);
      chk("stream_ctrl", a_oc, 8'h81);
      chk("stream_occ", a_occ, 1);
    end
    a_iv = 0;
    step();
    chk("drain_valid", a_ov, 0);
    chk("drain_bubble", a_oc, 0);
    chk("stream_cnt", a_cnt, 0);
    a_ir = 0;
    push_a(32'hAAAA0000); step();
    chk("A_head", a_od, 32'hAAAA0000);
    chk("A_occ", a_occ, 1);
    push_a(32'hBBBB0000); step();
    chk("AB_occ", a_occ, 2);
    chk("AB_ready", a_or, 0);
    chk("AB_cnt", a_cnt, 1);
    push_a(32'hCCCC0000); step(); step();
    chk("C_held_occ", a_occ, 2);
    chk("C_held_data", a_od, 32'hAAAA0000);
    chk("C_held_cnt", a_cnt, 3);
    a_ir = 1; step();
    chk("B_out", a_od, 32'hBBBB0000);
    chk("B_occ", a_occ, 1);
    step();
    chk("C_out", a_od, 32'hCCCC0000);
    chk("C_valid", a_ov, 1);
    a_iv = 0; step();
    chk("ABC_empty", a_ov, 0);
    chk("ABC_cnt", a_cnt, 3);
    a_ir = 0;
    push_a(32'h11110000); step();
    push_a(32'h22220000); step();
    chk("pre_flush_occ", a_occ, 2);
    push_a(32'hDDDD0000); a_fl = 1; step();
    chk("flush_valid", a_ov, 0);
    chk("flush_ctrl", a_oc, 0);
    chk("flush_occ", a_occ, 0);
    a_fl = 0; a_iv = 0; a_ir = 1; step();
    chk("D_dropped", a_ov, 0);
    chk("flush_cnt", a_cnt, 5);
    a_ir = 0;
    push_a(32'h33330000); step();
    push_a(32'h44440000); step();
    chk("pre_rst_occ", a_occ, 2);
    a_rst = 1; a_fl = 1; step();
    chk("mid_rst_occ", a_occ, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_ready", a_or, 0);
    a_rst = 0; a_fl = 0; a_iv = 0; a_ir = 1; step();
    chk("post_rst_valid", a_ov, 0);
    chk("post_rst_data", a_od, 0);
    chk("post_rst_ready", a_or, 1);
    step();
    b_rst = 0; #1;
    chk("b_bubble", b_oc, 8'h0F);
    chk("b_ready", b_or, 1);
    b_iv = 1; b_id = 32'h100; b_ic = 8'h81; step();
    chk("b_head", b_od, 32'h100);
    chk("b_ready_stall", b_or, 0);
    b_id = 32'h200;
    repeat (10) step();
    chk("b_sat", b_cnt, 7);
    chk("b_hold", b_od, 32'h100);
    chk("b_occ", b_occ, 1);
    b_ir = 1; b_id = 32'h201; #1;
    chk("b_ready_comb", b_or, 1);
    step();
    chk("b_replace", b_od, 32'h201);
    b_id = 32'h202; step();
    chk("b_tput", b_od, 32'h202);
    chk("b_tput_valid", b_ov, 1);
    b_iv = 0; step();
    chk("b_empty", b_ov, 0);
    chk("b_empty_ctrl", b_oc, 8'h0F);
    chk("b_cnt_kept", b_cnt, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
